// File: rtl/clkdiv_pkg.sv
// Shared constants and divisor helpers for the multi-channel clock divider.
package clkdiv_pkg;

    localparam int CNT_W_DEF = 8;
    localparam int DIV_W_MAX = 16;

    typedef logic [DIV_W_MAX-1:0] div_t;

    // A programmed divisor of zero behaves as divide-by-one.
    function automatic div_t eff_div(input div_t v);
        div_t r;
        if (v == 16'd0) begin
            r = 16'd1;
        end else begin
            r = v;
        end
        return r;
    endfunction

    function automatic div_t hi_thresh(input div_t d);
        return d >> 1;
    endfunction

endpackage

// File: rtl/clkdiv_chan.sv
// One divider channel: period counter, active/pending divisor and registered
// square-wave and clock-enable outputs.
module clkdiv_chan
    import clkdiv_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DEFAULT_DIV = 2
) (
    input  logic             hclkin,
    input  logic             resetn,
    input  logic             sync,
    input  logic             load,
    input  logic [CNT_W-1:0] div_in,
    output logic             clkout,
    output logic             ce_out,
    output logic             pend
);

    localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] RST_CNT = CNT_W'(DEFAULT_DIV - 1);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] ZERO    = {CNT_W{1'b0}};

    logic [CNT_W-1:0] d_r, p_r, cnt_r;
    logic             pend_r, clk_r, ce_r;

    logic [CNT_W-1:0] d_s, p_s, cnt_s, load_div_s, last_s;
    logic             pend_s, wrap_s, clk_s, ce_s;
    div_t             wide_s;

    // Next-state: count, divisor capture/apply, and outputs from the next count.
    always_comb begin
        wide_s     = div_t'(div_in);
        load_div_s = CNT_W'(eff_div(wide_s));
        last_s     = d_r - ONE;
        wrap_s     = (cnt_r == last_s);
        d_s        = d_r;
        p_s        = p_r;
        pend_s     = pend_r;
        cnt_s      = cnt_r;
        if (sync) begin
            cnt_s = ZERO;
            if (load) begin
                d_s    = load_div_s;
                p_s    = load_div_s;
                pend_s = 1'b0;
            end else if (pend_r) begin
                d_s    = p_r;
                pend_s = 1'b0;
            end else begin
                d_s    = d_r;
            end
        end else begin
            cnt_s = wrap_s ? ZERO : (cnt_r + ONE);
            if (wrap_s && pend_r) begin
                d_s    = p_r;
                pend_s = 1'b0;
            end else begin
                d_s    = d_r;
            end
            // A load landing on the wrap edge stays pending for one more period.
            if (load) begin
                p_s    = load_div_s;
                pend_s = 1'b1;
            end else begin
                p_s    = p_r;
            end
        end
        ce_s  = (cnt_s == ZERO);
        clk_s = (cnt_s < CNT_W'(hi_thresh(div_t'(d_s))));
    end

    // Channel state and output registers.
    always_ff @(posedge hclkin or negedge resetn) begin
        if (!resetn) begin
            d_r    <= RST_DIV;
            p_r    <= RST_DIV;
            cnt_r  <= RST_CNT;
            pend_r <= 1'b0;
            clk_r  <= 1'b0;
            ce_r   <= 1'b0;
        end else begin
            d_r    <= d_s;
            p_r    <= p_s;
            cnt_r  <= cnt_s;
            pend_r <= pend_s;
            clk_r  <= clk_s;
            ce_r   <= ce_s;
        end
    end

    assign clkout = clk_r;
    assign ce_out = ce_r;
    assign pend   = pend_r;

endmodule

// File: rtl/clkdiv_multi.sv
// NUM_CH independent programmable clock dividers sharing one source clock,
// reset and phase-realign strobe.
module clkdiv_multi
    import clkdiv_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DEFAULT_DIV = 2
) (
    input  logic                    hclkin,
    input  logic                    resetn,
    input  logic [NUM_CH*CNT_W-1:0] div_val,
    input  logic [NUM_CH-1:0]       div_load,
    input  logic                    sync,
    output logic [NUM_CH-1:0]       clkout,
    output logic [NUM_CH-1:0]       ce_out,
    output logic [NUM_CH-1:0]       pend
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        clkdiv_chan #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .hclkin (hclkin),
            .resetn (resetn),
            .sync   (sync),
            .load   (div_load[i]),
            .div_in (div_val[i*CNT_W +: CNT_W]),
            .clkout (clkout[i]),
            .ce_out (ce_out[i]),
            .pend   (pend[i])
        );
    end

endmodule

// File: tb/tb_clkdiv_multi.sv
// Scoreboard bench for clkdiv_multi: stimulus pushes the expected outputs for
// the coming edge, a monitor pops and compares one entry per rising edge.
module tb_clkdiv_multi;

    logic        hclkin = 1'b0;
    logic        resetn = 1'b0;
    logic [15:0] div_val = 16'd0;
    logic [1:0]  div_load = 2'b00;
    logic        sync = 1'b0;
    logic [1:0]  clkout, ce_out, pend;

    clkdiv_multi #(.NUM_CH(2), .CNT_W(8), .DEFAULT_DIV(2)) dut (
        .hclkin   (hclkin),
        .resetn   (resetn),
        .div_val  (div_val),
        .div_load (div_load),
        .sync     (sync),
        .clkout   (clkout),
        .ce_out   (ce_out),
        .pend     (pend)
    );

    always #5 hclkin = ~hclkin;

    typedef struct {
        logic [1:0] clk;
        logic [1:0] ce;
        logic [1:0] pd;
        string      tag;
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Expected per-channel position in the period, divisor and pend flag.
    int ed[2] = '{2, 2};
    int ph[2] = '{1, 1};
    bit ep[2] = '{1'b0, 1'b0};
    bit in_rst = 1'b1;

    function automatic void check(input string name, input logic [1:0] act, input logic [1:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, req);
        end
    endfunction

    task automatic adv(input int ch);
        ph[ch] = (ph[ch] + 1) % ed[ch];
    endtask

    task automatic step(input logic rn, input logic [1:0] ld, input int v0, input int v1,
                        input logic sy, input string tag);
        exp_t e;
        @(negedge hclkin);
        resetn   = rn;
        div_load = ld;
        div_val  = {8'(v1), 8'(v0)};
        sync     = sy;
        for (int ch = 0; ch < 2; ch++) begin
            e.clk[ch] = !in_rst && (ph[ch] < ed[ch] / 2);
            e.ce[ch]  = !in_rst && (ph[ch] == 0);
            e.pd[ch]  = !in_rst && ep[ch];
        end
        e.tag = tag;
        sbq.push_back(e);
    endtask

    task automatic idle(input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            adv(0);
            adv(1);
            step(1'b1, 2'b00, 0, 0, 1'b0, tag);
        end
    endtask

    // Monitor: one scoreboard entry is due after every rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge hclkin);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                check({e.tag, " clkout"}, clkout, e.clk);
                check({e.tag, " ce_out"}, ce_out, e.ce);
                check({e.tag, " pend"},   pend,   e.pd);
            end
        end
    end

    initial begin
        // Held in reset: all outputs low.
        repeat (3) step(1'b0, 2'b00, 0, 0, 1'b0, "reset");

        // Release: first edge starts a period on both channels.
        in_rst = 1'b0;
        adv(0); adv(1);
        step(1'b1, 2'b00, 0, 0, 1'b0, "release");
        idle(8, "div2");

        // Ch0 load 5 mid-period, applied at the following wrap.
        adv(0); adv(1); ep[0] = 1'b1;
        step(1'b1, 2'b01, 5, 0, 1'b0, "ld5");
        ph[0] = 0; ed[0] = 5; ep[0] = 1'b0; adv(1);
        step(1'b1, 2'b00, 0, 0, 1'b0, "apply5");
        idle(12, "div5");

        // Ch1 to 8, then load 4 and 6 back-to-back inside one period.
        adv(0); adv(1); ep[1] = 1'b1;
        step(1'b1, 2'b10, 0, 8, 1'b0, "ld8");
        adv(0); ph[1] = 0; ed[1] = 8; ep[1] = 1'b0;
        step(1'b1, 2'b00, 0, 0, 1'b0, "apply8");
        adv(0); adv(1); ep[1] = 1'b1;
        step(1'b1, 2'b10, 0, 4, 1'b0, "ld4");
        adv(0); adv(1);
        step(1'b1, 2'b10, 0, 6, 1'b0, "ld6");
        idle(5, "div8");
        adv(0); ph[1] = 0; ed[1] = 6; ep[1] = 1'b0;
        step(1'b1, 2'b00, 0, 0, 1'b0, "apply6");
        idle(5, "div6");

        // Load coinciding with the wrap edge waits one full old period.
        adv(0); adv(1); ep[1] = 1'b1;
        step(1'b1, 2'b10, 0, 7, 1'b0, "ld7_on_wrap");
        idle(5, "div6_pend");
        adv(0); ph[1] = 0; ed[1] = 7; ep[1] = 1'b0;
        step(1'b1, 2'b00, 0, 0, 1'b0, "apply7");
        idle(1, "div7");

        // Ch0 to 3, then a sync realigns ch0 (d=3) and ch1 (d=7).
        adv(0); adv(1); ep[0] = 1'b1;
        step(1'b1, 2'b01, 3, 0, 1'b0, "ld3");
        idle(3, "div5_pend");
        ph[0] = 0; ed[0] = 3; ep[0] = 1'b0; adv(1);
        step(1'b1, 2'b00, 0, 0, 1'b0, "apply3");
        idle(9, "div3_7");
        ph[0] = 0; ph[1] = 0;
        step(1'b1, 2'b00, 0, 0, 1'b1, "sync");
        idle(14, "aligned");

        // Sync applies a pending ch0 value and a same-edge ch1 load directly.
        idle(1, "pre_sync2");
        adv(0); adv(1); ep[0] = 1'b1;
        step(1'b1, 2'b01, 4, 0, 1'b0, "ld4_ch0");
        ph[0] = 0; ed[0] = 4; ep[0] = 1'b0;
        ph[1] = 0; ed[1] = 5; ep[1] = 1'b0;
        step(1'b1, 2'b10, 0, 5, 1'b1, "sync_ld5");
        idle(7, "div4_5");

        // Divisor 0 behaves as 1; then load 1 on a d=1 channel.
        idle(1, "pre_ld0");
        adv(0); adv(1); ep[0] = 1'b1;
        step(1'b1, 2'b01, 0, 0, 1'b0, "ld0");
        idle(2, "div4_pend");
        ph[0] = 0; ed[0] = 1; ep[0] = 1'b0; adv(1);
        step(1'b1, 2'b00, 0, 0, 1'b0, "apply0");
        idle(5, "div1");
        adv(0); adv(1); ep[0] = 1'b1;
        step(1'b1, 2'b01, 1, 0, 1'b0, "ld1");
        adv(0); adv(1); ep[0] = 1'b0;
        step(1'b1, 2'b00, 0, 0, 1'b0, "apply1");
        idle(3, "div1b");

        // Ch1 pending with cnt=3, then reset: outputs clear at once, load lost.
        adv(0); adv(1); ep[1] = 1'b1;
        step(1'b1, 2'b10, 0, 9, 1'b0, "ld9");
        in_rst = 1'b1;
        ed = '{2, 2}; ph = '{1, 1}; ep = '{1'b0, 1'b0};
        step(1'b0, 2'b00, 0, 0, 1'b0, "reset2");
        #1;
        check("async clr clkout", clkout, 2'b00);
        check("async clr ce_out", ce_out, 2'b00);
        check("async clr pend",   pend,   2'b00);
        step(1'b0, 2'b00, 0, 0, 1'b1, "reset2_sync");
        in_rst = 1'b0;
        adv(0); adv(1);
        step(1'b1, 2'b00, 0, 0, 1'b0, "release2");
        idle(8, "div2_again");

        repeat (3) @(negedge hclkin);
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", sbq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
